rescue_prime_drain: RTL and testbench
=====================================

# rescue_prime_drain

Result-side drain for the 13-lane `rescuePrime` permutation core. It snapshots the full `outState` array when `done` rises, then serializes the 39 field elements onto a valid/ready word stream for the host. It sits between the core's parallel output and the downstream sponge/host interface. It frees the core to start the next permutation while the previous result is still draining.

## Interface
- `N_BITS`, default 254: field element width.
- `PRIME_MODULUS`, default 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001: modulus, used only by the range check.
- `STATE_SIZE`, default 3: elements per lane.
- `NUM_LANES`, default 13: parallel permutation lanes.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `outState` input [N_BITS-1:0] [STATE_SIZE][NUM_LANES]: core result array.
- `done` input 1: core completion, level; only its rising edge matters.
- `m_data` output N_BITS: current word.
- `m_valid` output 1: `m_data` is valid.
- `m_ready` input 1: downstream accepts the word.
- `m_last` output 1: final word of the snapshot.
- `m_lane` output 4: lane index of the current word.
- `m_elem` output 2: element index of the current word.
- `busy` output 1: a snapshot is held and not fully drained.
- `overrun` output 1: sticky; a result was dropped.
- `range_err` output 1: sticky; only present with the macro, otherwise tied 0.

## Operation
- `done_q` register tracks `done`. Edge = `done & ~done_q`.
- States:
  - IDLE: `busy`=0, `m_valid`=0.
  - STREAM: `busy`=1, `m_valid`=1.
- IDLE + edge:
  - Copy all of `outState` into the snapshot buffer.
  - Set `lane`=0, `elem`=0.
  - Go to STREAM.
- Word order is lane-major: (lane0, e0), (lane0, e1), (lane0, e2), (lane1, e0) … (lane12, e2). That is 39 words, word index = lane*STATE_SIZE + elem.
- `m_data` = buffer[elem][lane]. `m_lane`/`m_elem` show the counters. `m_last` = (lane==NUM_LANES-1 && elem==STATE_SIZE-1).
- Handshake = `m_valid & m_ready`.
  - On handshake, `elem` increments. When `elem` wraps from STATE_SIZE-1 to 0, `lane` increments.
  - A handshake on the `m_last` word returns the block to IDLE.
- Edge while in STREAM, with no final handshake in the same cycle:
  - The buffer is not modified.
  - `overrun` is set.
- Edge in the same cycle as the final handshake:
  - The new result is captured and counters reset to 0.
  - State stays STREAM with no bubble. `overrun` is not set.
- `overrun` and `range_err` clear only on reset.
- Asserting reset mid-stream:
  - Discards the snapshot.
  - All outputs return immediately to their reset values.

## Timing
- Reset values:
  - `m_valid`, `m_last`, `busy`, `overrun` and `range_err` are 0.
  - `m_data`, `m_lane` and `m_elem` are 0.
  - `done_q` is 0, so a `done` already high when reset is released counts as an edge on the first clock.
- Latency: an edge sampled at clock k makes `m_valid`=1 with word 0 immediately after edge k.
- Throughput is one word per cycle while `m_ready`=1. The minimum drain is 39 cycles.
- While `m_valid` & !`m_ready`, `m_data`, `m_lane`, `m_elem` and `m_last` hold stable.
- `m_valid` never drops without a handshake, except on reset.
- `outState` only needs to be stable in the edge cycle. After that cycle the core may change it freely.

## Configuration
- `RESCUE_DRAIN_RANGE_CHECK_EN` defined:
  - Each word that completes a handshake is compared against `PRIME_MODULUS`.
  - If `m_data` ≥ `PRIME_MODULUS`, `range_err` sets one cycle later and stays set until reset.
  - Data still passes through unmodified.
- Undefined: no comparator is built and `range_err` is constant 0.

## Test plan
- Reset, then load the array with value 100*lane + elem and pulse `done` for 1 cycle with `m_ready`=1.
  - Expect 39 consecutive words 0, 1, 2, 100, 101, … 1202.
  - `m_last` is high only on 1202. `busy` drops the cycle after.
- Backpressure: toggle `m_ready` 1/0 every cycle.
  - All 39 words arrive in order with no duplicates.
  - `m_data` stays stable on every stall cycle.
- Overrun: raise `done` again after the 10th handshake.
  - Stream continues with the original data.
  - `overrun`=1. No second snapshot is taken.
- Back-to-back: hold `m_ready`=1 and raise `done` in the exact cycle of the final handshake with new data 5000+index.
  - Word 5000 follows 1202 with no gap.
  - `overrun` stays 0.
- Reset mid-stream: assert reset after 20 words.
  - `m_valid`, `busy` and `overrun` go to 0 at once.
  - A new `done` restarts at lane 0, elem 0.
- With `RESCUE_DRAIN_RANGE_CHECK_EN`: set lane 4, elem 1 to PRIME_MODULUS and all other words to 7.
  - `range_err` sets after word 13 is accepted.
  - It is still 1 after the stream ends. Without the macro it stays 0.

Source files
------------

// File: rtl/rescue_prime_drain_if.sv
// Word stream between the result drain and the downstream sponge/host.
// The master drives one field element per handshake together with its lane/element tag.
interface rescue_prime_drain_if #(
   parameter int N_BITS = 254
) ();
   logic [N_BITS-1:0] data;
   logic              valid;
   logic              ready;
   logic              last;
   logic [3:0]        lane;
   logic [1:0]        elem;

   modport master (output data, valid, last, lane, elem, input ready);
   modport slave  (input data, valid, last, lane, elem, output ready);
endinterface

// File: rtl/rescue_prime_drain.sv
// Snapshots the rescuePrime outState array on the rising edge of done and streams it out lane-major.
// Optional range check on accepted words: define RESCUE_DRAIN_RANGE_CHECK_EN.
//
// state  | meaning
// IDLE   | no snapshot held, waiting for a done rising edge
// STREAM | snapshot held, presenting word (lane, elem)
module rescue_prime_drain #(
   parameter int                N_BITS        = 254,
   parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
   parameter int                STATE_SIZE    = 3,
   parameter int                NUM_LANES     = 13
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_BITS-1:0]   outState [STATE_SIZE][NUM_LANES],
   input  logic                done,
   rescue_prime_drain_if.master m,
   output logic                busy,
   output logic                overrun,
   output logic                range_err
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q, state_d;
   logic              done_q;
   logic [3:0]        lane_q, lane_d;
   logic [1:0]        elem_q, elem_d;
   logic              overrun_q, overrun_d;
   logic              capture;
   logic              done_edge;
   logic              hs;
   logic              at_last;
   logic [N_BITS-1:0] snap_q [STATE_SIZE][NUM_LANES];

   assign done_edge = done & ~done_q;
   assign hs        = (state_q == STREAM) & m.ready;
   assign at_last   = (lane_q == 4'(NUM_LANES - 1)) && (elem_q == 2'(STATE_SIZE - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         lane_q    <= '0;
         elem_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         done_q    <= done;
         lane_q    <= lane_d;
         elem_q    <= elem_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      lane_d    = lane_q;
      elem_d    = elem_q;
      overrun_d = overrun_q;
      capture   = 1'b0;
      case (state_q)
         IDLE: begin
            if (done_edge) begin
               capture = 1'b1;
               state_d = STREAM;
               lane_d  = '0;
               elem_d  = '0;
            end
         end
         STREAM: begin
            if (hs && at_last) begin
               // A new result landing on the final handshake chains straight into the next stream.
               lane_d = '0;
               elem_d = '0;
               if (done_edge) capture = 1'b1;
               else           state_d = IDLE;
            end else begin
               if (hs) begin
                  if (elem_q == 2'(STATE_SIZE - 1)) begin
                     elem_d = '0;
                     lane_d = lane_q + 4'd1;
                  end else begin
                     elem_d = elem_q + 2'd1;
                  end
               end
               if (done_edge) overrun_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Snapshot storage carries no reset; m.data is masked to zero outside STREAM instead.
   always_ff @(posedge clk) begin
      if (capture) snap_q <= outState;
   end

   assign m.valid = (state_q == STREAM);
   assign m.data  = m.valid ? snap_q[elem_q][lane_q] : '0;
   assign m.last  = m.valid & at_last;
   assign m.lane  = lane_q;
   assign m.elem  = elem_q;
   assign busy    = (state_q == STREAM);
   assign overrun = overrun_q;

`ifdef RESCUE_DRAIN_RANGE_CHECK_EN
   logic range_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                               range_q <= 1'b0;
      else if (hs && (m.data >= PRIME_MODULUS)) range_q <= 1'b1;
   end
   assign range_err = range_q;
`else
   assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_rescue_prime_drain.sv
// Directed bench for rescue_prime_drain: streaming, backpressure, overrun, back-to-back, reset, range check.
module tb_rescue_prime_drain;
   localparam logic [253:0] PM = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   logic         clk;
   logic         reset;
   logic         done;
   logic [253:0] out_state [3][13];
   logic         busy, overrun, range_err;
   logic [253:0] exp_w [39];
   int           checks = 0;
   int           errs   = 0;

   rescue_prime_drain_if #(.N_BITS(254)) m_if ();

   rescue_prime_drain dut (
      .clk      (clk),
      .reset    (reset),
      .outState (out_state),
      .done     (done),
      .m        (m_if.master),
      .busy     (busy),
      .overrun  (overrun),
      .range_err(range_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic set_data(input int base, input int ls, input int es);
      for (int l = 0; l < 13; l++)
         for (int e = 0; e < 3; e++) begin
            out_state[e][l] = 254'(base + ls * l + es * e);
            exp_w[l * 3 + e] = 254'(base + ls * l + es * e);
         end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0; done = 1'b0; m_if.ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Returns at the negedge where word 0 of the new snapshot is presented.
   task automatic pulse_done();
      @(negedge clk); done = 1'b1;
      @(negedge clk); done = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; done = 1'b0; m_if.ready = 1'b0; set_data(0, 100, 1);
      repeat (2) @(negedge clk);
      checks++; if (m_if.valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b want 0", m_if.valid); end
      checks++; if (m_if.last !== 1'b0) begin errs++; $display("FAIL rst_last: got %b want 0", m_if.last); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      checks++; if (range_err !== 1'b0) begin errs++; $display("FAIL rst_range_err: got %b want 0", range_err); end
      checks++; if (m_if.data !== 254'd0) begin errs++; $display("FAIL rst_data: got %0h want 0", m_if.data); end
      checks++; if (m_if.lane !== 4'd0 || m_if.elem !== 2'd0) begin errs++; $display("FAIL rst_idx: got %0d/%0d want 0/0", m_if.lane, m_if.elem); end
      // done already high at reset release counts as an edge
      done = 1'b1;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); done = 1'b0;
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== 254'd0) begin errs++; $display("FAIL rst_done_high: got valid %b data %0h want 1/0", m_if.valid, m_if.data); end
   endtask

   task automatic test_stream();
      apply_reset();
      set_data(0, 100, 1);
      m_if.ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 39; i++) begin
         checks++; if (m_if.valid !== 1'b1 || m_if.data !== exp_w[i]) begin errs++; $display("FAIL stream_word%0d: got valid %b data %0d want 1/%0d", i, m_if.valid, m_if.data, exp_w[i]); end
         checks++; if (m_if.last !== (i == 38)) begin errs++; $display("FAIL stream_last%0d: got %b want %b", i, m_if.last, (i == 38)); end
         checks++; if (m_if.lane !== 4'(i / 3) || m_if.elem !== 2'(i % 3)) begin errs++; $display("FAIL stream_idx%0d: got %0d/%0d want %0d/%0d", i, m_if.lane, m_if.elem, i / 3, i % 3); end
         checks++; if (busy !== 1'b1) begin errs++; $display("FAIL stream_busy%0d: got %b want 1", i, busy); end
         @(negedge clk);
      end
      checks++; if (busy !== 1'b0 || m_if.valid !== 1'b0) begin errs++; $display("FAIL stream_end: got busy %b valid %b want 0/0", busy, m_if.valid); end
   endtask

   task automatic test_backpressure();
      int           idx;
      logic [253:0] prev_data;
      logic         prev_ready;
      apply_reset();
      set_data(20000, 100, 1);
      pulse_done();
      idx = 0; prev_ready = 1'b1; prev_data = '0;
      for (int c = 0; c < 200 && idx < 39; c++) begin
         checks++; if (m_if.valid !== 1'b1 || m_if.data !== exp_w[idx]) begin errs++; $display("FAIL bp_word%0d: got valid %b data %0d want 1/%0d", idx, m_if.valid, m_if.data, exp_w[idx]); end
         checks++; if (m_if.lane !== 4'(idx / 3) || m_if.elem !== 2'(idx % 3)) begin errs++; $display("FAIL bp_idx%0d: got %0d/%0d want %0d/%0d", idx, m_if.lane, m_if.elem, idx / 3, idx % 3); end
         if (!prev_ready) begin
            checks++; if (m_if.data !== prev_data) begin errs++; $display("FAIL bp_stall%0d: got %0d want %0d", idx, m_if.data, prev_data); end
         end
         prev_data  = m_if.data;
         m_if.ready = (c % 2 == 1);
         prev_ready = m_if.ready;
         if (m_if.ready) idx++;
         @(negedge clk);
      end
      m_if.ready = 1'b1;
      checks++; if (idx !== 39) begin errs++; $display("FAIL bp_count: got %0d want 39", idx); end
      checks++; if (m_if.valid !== 1'b0) begin errs++; $display("FAIL bp_end: got %b want 0", m_if.valid); end
   endtask

   task automatic test_overrun();
      apply_reset();
      set_data(0, 100, 1);
      m_if.ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 39; i++) begin
         if (i == 10) begin
            for (int l = 0; l < 13; l++)
               for (int e = 0; e < 3; e++) out_state[e][l] = 254'(9000 + l * 3 + e);
            done = 1'b1;
         end
         if (i == 11) done = 1'b0;
         checks++; if (m_if.data !== exp_w[i]) begin errs++; $display("FAIL ovr_word%0d: got %0d want %0d", i, m_if.data, exp_w[i]); end
         checks++; if (overrun !== (i >= 11)) begin errs++; $display("FAIL ovr_flag%0d: got %b want %b", i, overrun, (i >= 11)); end
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      checks++; if (m_if.valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL ovr_no_resnap: got valid %b busy %b want 0/0", m_if.valid, busy); end
      checks++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      set_data(0, 100, 1);
      m_if.ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 39; i++) begin
         checks++; if (m_if.data !== exp_w[i]) begin errs++; $display("FAIL b2b_first%0d: got %0d want %0d", i, m_if.data, exp_w[i]); end
         if (i == 38) begin
            set_data(5000, 3, 1);
            done = 1'b1;
         end
         @(negedge clk);
      end
      done = 1'b0;
      for (int i = 0; i < 39; i++) begin
         checks++; if (m_if.valid !== 1'b1 || m_if.data !== exp_w[i]) begin errs++; $display("FAIL b2b_second%0d: got valid %b data %0d want 1/%0d", i, m_if.valid, m_if.data, exp_w[i]); end
         checks++; if (m_if.lane !== 4'(i / 3) || m_if.elem !== 2'(i % 3)) begin errs++; $display("FAIL b2b_idx%0d: got %0d/%0d want %0d/%0d", i, m_if.lane, m_if.elem, i / 3, i % 3); end
         @(negedge clk);
      end
      checks++; if (overrun !== 1'b0) begin errs++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
      checks++; if (m_if.valid !== 1'b0) begin errs++; $display("FAIL b2b_end: got %b want 0", m_if.valid); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      set_data(0, 100, 1);
      m_if.ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 20; i++) begin
         if (i == 5) done = 1'b1;
         if (i == 6) done = 1'b0;
         checks++; if (m_if.data !== exp_w[i]) begin errs++; $display("FAIL rmid_word%0d: got %0d want %0d", i, m_if.data, exp_w[i]); end
         @(negedge clk);
      end
      checks++; if (overrun !== 1'b1 || m_if.valid !== 1'b1) begin errs++; $display("FAIL rmid_pre: got overrun %b valid %b want 1/1", overrun, m_if.valid); end
      reset = 1'b0;
      #1;
      checks++; if (m_if.valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin errs++; $display("FAIL rmid_async: got valid %b busy %b overrun %b want 0/0/0", m_if.valid, busy, overrun); end
      checks++; if (m_if.data !== 254'd0 || m_if.last !== 1'b0 || m_if.lane !== 4'd0) begin errs++; $display("FAIL rmid_outs: got data %0d last %b lane %0d want 0/0/0", m_if.data, m_if.last, m_if.lane); end
      @(negedge clk); reset = 1'b1;
      set_data(300, 100, 1);
      pulse_done();
      checks++; if (m_if.valid !== 1'b1 || m_if.data !== 254'd300 || m_if.lane !== 4'd0 || m_if.elem !== 2'd0) begin errs++; $display("FAIL rmid_restart: got valid %b data %0d idx %0d/%0d want 1/300/0/0", m_if.valid, m_if.data, m_if.lane, m_if.elem); end
   endtask

   task automatic test_range();
      logic         exp_re;
      logic [253:0] exp_d;
      apply_reset();
      for (int l = 0; l < 13; l++)
         for (int e = 0; e < 3; e++) out_state[e][l] = 254'd7;
      out_state[1][4] = PM;
      m_if.ready = 1'b1;
      pulse_done();
      for (int i = 0; i < 39; i++) begin
         exp_d = (i == 13) ? PM : 254'd7;
`ifdef RESCUE_DRAIN_RANGE_CHECK_EN
         exp_re = (i >= 14);
`else
         exp_re = 1'b0;
`endif
         checks++; if (m_if.data !== exp_d) begin errs++; $display("FAIL range_word%0d: got %0h want %0h", i, m_if.data, exp_d); end
         checks++; if (range_err !== exp_re) begin errs++; $display("FAIL range_flag%0d: got %b want %b", i, range_err, exp_re); end
         @(negedge clk);
      end
`ifdef RESCUE_DRAIN_RANGE_CHECK_EN
      exp_re = 1'b1;
`else
      exp_re = 1'b0;
`endif
      checks++; if (range_err !== exp_re || m_if.valid !== 1'b0) begin errs++; $display("FAIL range_end: got range_err %b valid %b want %b/0", range_err, m_if.valid, exp_re); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
      test_range();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end
endmodule
